// File: rtl/gf2mz_reduce_if.sv
// gf2mz_reduce_if: start/done handshake, product-read port and result-write port of gf2mz_reduce
//   master (controller/memories side): drives start, c_din; observes everything else
//   slave  (gf2mz_reduce side):        drives done, busy, c_rd_en, c_addr, r_we, r_addr, r_dout
//   cycles (32-bit run length) exists only when GF2MZ_RED_CNT_EN is defined
interface gf2mz_reduce_if #(
    parameter int AW = 8,
    parameter int M  = 67
);
    logic          start, done, busy, c_rd_en, r_we;
    logic [AW-1:0] c_addr, r_addr;
    logic [M-1:0]  c_din, r_dout;
`ifdef GF2MZ_RED_CNT_EN
    logic [31:0]   cycles;
`endif
    modport master (
        output start, c_din,
        input  done, busy, c_rd_en, c_addr, r_we, r_addr, r_dout
`ifdef GF2MZ_RED_CNT_EN
        , cycles
`endif
    );
    modport slave (
        input  start, c_din,
        output done, busy, c_rd_en, c_addr, r_we, r_addr, r_dout
`ifdef GF2MZ_RED_CNT_EN
        , cycles
`endif
    );
endinterface

// File: rtl/gf2mz_reduce.sv
// gf2mz_reduce: R(z) = C(z) mod (z^n + z^k + 1) over GF(2^m)[z], one buffer word per cycle
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : gf2mz_reduce_if.slave
//              start/done/busy handshake, c_rd_en/c_addr/c_din product read (1-cycle latency),
//              r_we/r_addr/r_dout result write, cycles (only with GF2MZ_RED_CNT_EN)
//   Optional feature macro: GF2MZ_RED_CNT_EN (adds the 32-bit busy-cycle counter)
module gf2mz_reduce #(
    parameter int n  = 97,
    parameter int m  = 67,
    parameter int k  = 6,
    parameter int AW = $clog2(2*n-1)
) (
    input logic         clk,
    input logic         rst,
    gf2mz_reduce_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, REDUCE, WRITE, FIN} state_t;
    // LOAD needs one extra cycle after the last read to capture its data
    localparam logic [AW-1:0] LAST = AW'(2*n-1);
    localparam logic [AW-1:0] TOP  = AW'(2*n-2);
    localparam logic [AW-1:0] NN   = AW'(n);
    localparam logic [AW-1:0] NM1  = AW'(n-1);
    localparam logic [AW-1:0] KK   = AW'(k);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d, lo, mid;
    logic [m-1:0]  buf_q [2*n-1];
    logic          rd, wr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + AW'(1);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.start) state_d = LOAD;
            end
            LOAD: if (cnt_q == LAST) begin
                state_d = REDUCE;
                cnt_d   = TOP;
            end
            REDUCE: begin
                cnt_d = cnt_q - AW'(1);
                if (cnt_q == NN) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end
            end
            WRITE: if (cnt_q == NM1) begin
                state_d = FIN;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // z^i = z^(i-n) * (z^k + 1): fold index i into i-n and i-n+k; descending order
    // guarantees a fold landing at or above n is handled by a later iteration
    assign lo  = cnt_q - NN;
    assign mid = lo + KK;

    always_ff @(posedge clk) begin
        if (state_q == LOAD && cnt_q != '0) buf_q[cnt_q - AW'(1)] <= bus.c_din;
        if (state_q == REDUCE) begin
            buf_q[lo]  <= buf_q[lo] ^ buf_q[cnt_q];
            buf_q[mid] <= buf_q[mid] ^ buf_q[cnt_q];
        end
    end

    assign rd          = state_q == LOAD && cnt_q != LAST;
    assign wr          = state_q == WRITE;
    assign bus.busy    = state_q != IDLE;
    assign bus.done    = state_q == FIN;
    assign bus.c_rd_en = rd;
    assign bus.c_addr  = rd ? cnt_q : '0;
    assign bus.r_we    = wr;
    assign bus.r_addr  = wr ? cnt_q : '0;
    assign bus.r_dout  = wr ? buf_q[cnt_q] : '0;

`ifdef GF2MZ_RED_CNT_EN
    logic [31:0] cyc_q, cyc_d;
    assign cyc_d = (state_q == IDLE) ? (bus.start ? '0 : cyc_q) : cyc_q + 32'd1;
    always_ff @(posedge clk) begin
        if (rst) cyc_q <= '0;
        else     cyc_q <= cyc_d;
    end
    assign bus.cycles = cyc_q;
`endif
endmodule

// File: tb/tb_gf2mz_reduce.sv
// tb_gf2mz_reduce: scoreboard bench for gf2mz_reduce at n=5, m=4, k=2 (P = z^5 + z^2 + 1)
module tb_gf2mz_reduce;
    localparam int N = 5, M = 4, K = 2, AW = 4;

    logic clk, rst;
    logic [M-1:0] mem [2*N-1];
    logic [7:0] sb [$];
    int checks = 0, errors = 0, done_cnt = 0;
    logic [AW-1:0] rd_exp = '0;

    gf2mz_reduce_if #(.AW(AW), .M(M)) bus ();
    gf2mz_reduce #(.n(N), .m(M), .k(K), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.c_din <= bus.c_rd_en ? mem[bus.c_addr] : '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.r_we) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0d data %h", bus.r_addr, bus.r_dout);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if ({bus.r_addr, bus.r_dout} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                             bus.r_addr, bus.r_dout, e[7:4], e[3:0]);
                end
            end
        end
        checks++;
        if ((bus.c_rd_en && bus.r_we) || (!bus.c_rd_en && bus.c_addr != '0) ||
            (!bus.r_we && (bus.r_addr != '0 || bus.r_dout != '0))) begin
            errors++;
            $display("FAIL strobes: c_rd_en %b c_addr %0d r_we %b r_addr %0d r_dout %h",
                     bus.c_rd_en, bus.c_addr, bus.r_we, bus.r_addr, bus.r_dout);
        end
        if (bus.c_rd_en) begin
            checks++;
            if (bus.c_addr !== rd_exp) begin
                errors++;
                $display("FAIL read_addr: got %0d expected %0d", bus.c_addr, rd_exp);
            end
            rd_exp = rd_exp + 1'b1;
        end else if (!bus.busy) rd_exp = '0;
        if (bus.done) done_cnt++;
    end

    // reduction via running z^i mod P, independent of the fold loop
    function automatic logic [19:0] model(input logic [35:0] c);
        logic [5:0] p;
        logic [19:0] r;
        p = 6'd1;
        r = '0;
        for (int i = 0; i < 2*N-1; i++) begin
            for (int j = 0; j < N; j++) if (p[j]) r[4*j +: 4] ^= c[4*i +: 4];
            p = p << 1;
            if (p[5]) p ^= 6'b100101;
        end
        return r;
    endfunction

    task automatic load(input logic [35:0] c, input logic [19:0] r);
        for (int i = 0; i < 2*N-1; i++) mem[i] = c[4*i +: 4];
        for (int j = 0; j < N; j++) sb.push_back({4'(j), r[4*j +: 4]});
    endtask

    // j counts busy cycles after the start edge; extra start pulses at sa/sb, reset at rc
    task automatic run(input int sa, input int sb_at, input int rc, input bit imm, output int lat);
        if (!imm) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        for (int j = 1; j <= 4*N+10; j++) begin
            if (bus.done && lat < 0) lat = j;
            bus.start = (j == sa || j == sb_at);
            rst = (j == rc);
            @(negedge clk);
            bus.start = 1'b0;
            rst = 1'b0;
            if (lat >= 0 || j == rc) break;
        end
    endtask

    task automatic test(input string nm, input logic [35:0] c, input logic [19:0] r,
                        input int sa, input int sb_at, input bit imm);
        int lat, d0;
        load(c, r);
        d0 = done_cnt;
        run(sa, sb_at, 0, imm, lat);
        chk({nm, "_latency"}, lat, 4*N);
        chk({nm, "_busy_after"}, bus.busy, 0);
        chk({nm, "_writes_left"}, sb.size(), 0);
        chk({nm, "_done_pulses"}, done_cnt - d0, 1);
`ifdef GF2MZ_RED_CNT_EN
        chk({nm, "_cycles"}, bus.cycles, 4*N);
`endif
    endtask

    initial begin
        int lat;
        logic [35:0] c;
        rst = 1'b1;
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.done, bus.busy, bus.c_rd_en, bus.c_addr, bus.r_we, bus.r_addr, bus.r_dout}, 0);
`ifdef GF2MZ_RED_CNT_EN
        chk("reset_cycles", bus.cycles, 0);
`endif
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("start_with_rst_ignored", bus.busy, 0);

        test("single_top", 36'h1_0000_0000, 20'h01101, 0, 0, 0);
        test("low_half", 36'h0_0000_B9753, 20'hB9753, 0, 0, 0);
        test("all_f", 36'hF_FFFF_FFFF, 20'h0F00F, 0, 0, 0);

        load(36'hF_FFFF_FFFF, 20'h0F00F);
        run(0, 0, 2*N+2, 0, lat);
        chk("abort_outputs", {bus.done, bus.busy, bus.c_rd_en, bus.c_addr, bus.r_we, bus.r_addr, bus.r_dout}, 0);
`ifdef GF2MZ_RED_CNT_EN
        chk("abort_cycles", bus.cycles, 0);
`endif
        sb.delete();
        repeat (30) @(negedge clk);
        chk("abort_stays_idle", bus.busy, 0);
        test("after_abort", 36'h0_0000_B9753, 20'hB9753, 0, 0, 0);

        test("ignore_starts", 36'h1_0000_0000, 20'h01101, 3, 4*N, 0);
        test("first_idle_start", 36'h0_0000_B9753, 20'hB9753, 0, 0, 1);

        for (int t = 0; t < 100; t++) begin
            c = {4'($urandom), 32'($urandom)};
            test("random", c, model(c), 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gf2mz_reduce.md
GF2MZ_REDUCE -- requirements
Module: gf2mz_reduce

Interface
REQ-001 SHALL have parameter n, default 97, meaning the degree of P(z) and the number of result coefficients.
REQ-002 SHALL have parameter m, default 67, meaning the coefficient width in bits (GF(2^m) element).
REQ-003 SHALL have parameter k, default 6, meaning the middle exponent of P(z) = z^n + z^k + 1, with 1 <= k <= n-1.
REQ-004 SHALL have parameter AW, default $clog2(2n-1), meaning the address width for both memory ports.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, the reset, which is synchronous and active-high.
REQ-007 SHALL have port start, input, 1, a one-cycle request to reduce the product held upstream.
REQ-008 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-009 SHALL have port busy, output, 1, high from the cycle after start is accepted until the cycle done is high, inclusive.
REQ-010 SHALL have port c_rd_en, output, 1, the read strobe to the upstream gf2mz_top product memory (mem_C).
REQ-011 SHALL have port c_addr, output, AW, the product coefficient index, 0..2n-2.
REQ-012 SHALL have port c_din, input, m, the product coefficient, valid exactly one cycle after c_rd_en.
REQ-013 SHALL have port r_we, output, 1, the result memory write enable.
REQ-014 SHALL have port r_addr, output, AW, the result coefficient index, 0..n-1.
REQ-015 SHALL have port r_dout, output, m, the reduced coefficient.
REQ-016 SHALL have port cycles, output, 32, the cycle count, present only under GF2MZ_RED_CNT_EN.

Function
REQ-017 SHALL compute R(z) = C(z) mod (z^n + z^k + 1) over GF(2^m)[z], where C has 2n-1 coefficients and coefficient addition is bitwise XOR.
REQ-018 SHALL hold a local buffer buf[0..2n-2] of m-bit words.
REQ-019 SHALL implement the FSM states IDLE, LOAD, REDUCE, WRITE and FIN.
REQ-020 SHALL move from IDLE to LOAD on the edge where start=1; start in any other state is ignored.
REQ-021 LOAD SHALL issue c_rd_en with c_addr = 0..2n-2 on consecutive cycles, capture c_din into buf one cycle later, and last exactly 2n cycles.
REQ-022 REDUCE SHALL process one index per cycle, i = 2n-2 down to n, doing buf[i-n] ^= buf[i] and buf[i-n+k] ^= buf[i] in the same cycle (n-1 cycles).
REQ-023 REDUCE order SHALL be strictly descending, so that a term folded into an index >= n is re-reduced by a later iteration.
REQ-024 WRITE SHALL assert r_we with r_addr = 0..n-1 and r_dout = buf[r_addr] on consecutive cycles (n cycles).
REQ-025 FIN SHALL last 1 cycle with done=1, then return to IDLE.
REQ-026 Latency: with start sampled at edge T, done SHALL be high in cycle T+4n, and busy SHALL be low again at T+4n+1.
REQ-027 A start coinciding with the FIN cycle SHALL be ignored; a start in the first IDLE cycle after FIN SHALL be accepted.
REQ-028 c_rd_en and r_we SHALL never be high in the same cycle; c_addr, r_addr and r_dout SHALL be 0 whenever their strobe is low.
REQ-029 SHALL reuse the buffer from run to run without clearing it, because every entry is overwritten during LOAD.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE and drive done, busy, c_rd_en, c_addr, r_we, r_addr, r_dout and cycles to 0.
REQ-031 rst during any state SHALL abort the run with no further memory accesses, and start in the same cycle as rst SHALL be ignored.
REQ-032 Buffer contents need not be reset.

Configuration
REQ-033 With GF2MZ_RED_CNT_EN defined, cycles SHALL clear on accepted start, increment each busy cycle, hold after done (value 4n), and clear on rst.
REQ-034 Without GF2MZ_RED_CNT_EN, the cycles port and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Test: n=5, k=2, m=4, C = {c8=1, others 0} -> r[0..4] = 1,0,1,1,0; done exactly 20 cycles after start.
REQ-036 Test: n=5, k=2, C with c0..c4 = 3,5,7,9,B and c5..c8 = 0 -> output equals input low half; 5 r_we pulses, addresses 0..4.
REQ-037 Test: n=5, k=2, all nine coefficients = F -> r = F,0,0,F,0, checked against a software model; random C over 100 runs matches the model.
REQ-038 Test: assert rst in REDUCE cycle 2 -> next cycle all outputs 0, no r_we ever; a fresh start then gives correct results.
REQ-039 Test: pulse start during LOAD and during FIN -> ignored; the single run completes normally with exactly one done pulse.
REQ-040 Test: GF2MZ_RED_CNT_EN, n=5 -> cycles = 20 after done; without the macro, the build has no cycles port.
